accelerator_lstm_sequencer: RTL and testbench

Sequencer for the standard-LSTM accelerator controller. On START it loads one LSTM step's bias vector (length L) and input vector (length X) from a local word memory into the controller. Loading is element by element with a per-element acknowledge. It then launches the controller and writes the returned hidden-state vector back to memory. It sits between the host-visible memory and `accelerator_controller`, replacing the stimulus-driven element streaming for B_IN and X_IN.

---
 rtl/accelerator_lstm_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_accelerator_lstm_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_lstm_sequencer.sv
// Streams one LSTM step's bias and input vectors from word memory into the controller, launches it, stores the hidden-state results.
// Latency: START -> first read 1 cycle, element enable 2 cycles; 2 cycles/element minimum; READY 1 cycle after CTRL_READY.
// Backpressure: each element is held on CTRL_*_IN until its acknowledge arrives; results beyond L are dropped and flag ERROR.
module accelerator_lstm_sequencer #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int ADDRESS_SIZE = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_i,
  output logic                    ready_o,
  output logic                    error_o,
  input  logic [DATA_SIZE-1:0]    size_x_i,
  input  logic [DATA_SIZE-1:0]    size_l_i,
  input  logic [ADDRESS_SIZE-1:0] mem_base_i,
  output logic [ADDRESS_SIZE-1:0] mem_address_o,
  output logic                    mem_read_o,
  input  logic [DATA_SIZE-1:0]    mem_data_i,
  output logic                    mem_write_o,
  output logic [DATA_SIZE-1:0]    mem_data_o,
  output logic                    ctrl_start_o,
  input  logic                    ctrl_ready_i,
  output logic                    ctrl_b_in_enable_o,
  output logic                    ctrl_x_in_enable_o,
  output logic [DATA_SIZE-1:0]    ctrl_b_in_o,
  output logic [DATA_SIZE-1:0]    ctrl_x_in_o,
  input  logic                    ctrl_b_out_enable_i,
  input  logic                    ctrl_x_out_enable_i,
  input  logic                    ctrl_h_out_enable_i,
  input  logic [DATA_SIZE-1:0]    ctrl_h_out_i
);

  // One extra bit so index+1 and count+1 never overflow in comparisons.
  localparam int CW = ((CONTROL_SIZE > DATA_SIZE) ? CONTROL_SIZE : DATA_SIZE) + 1;
  localparam int AW = ADDRESS_SIZE;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_PRESENT, S_WAIT_ACK, S_LAUNCH, S_COLLECT, S_DONE
  } state_t;

  typedef enum logic {PH_B, PH_X} phase_t;

  state_t                  state_q, state_d;
  phase_t                  phase_q, phase_d;
  logic [CONTROL_SIZE-1:0] index_q, index_d;
  logic [CONTROL_SIZE-1:0] count_q, count_d;
  logic [DATA_SIZE-1:0]    size_l_q, size_l_d;
  logic [DATA_SIZE-1:0]    size_x_q, size_x_d;
  logic [AW-1:0]           base_q, base_d;
  logic [DATA_SIZE-1:0]    b_data_q, b_data_d;
  logic [DATA_SIZE-1:0]    x_data_q, x_data_d;
  logic                    error_q, error_d;
  logic                    wr_vld_q, wr_vld_d;
  logic [AW-1:0]           wr_addr_q, wr_addr_d;
  logic [DATA_SIZE-1:0]    wr_data_q, wr_data_d;

  logic                    ack;
  logic                    advance;
  logic                    last_elem;
  logic                    h_fit;
  logic [CW-1:0]           h_total;
  logic [DATA_SIZE-1:0]    phase_size;
  logic [AW-1:0]           rd_addr;
  logic [AW-1:0]           wr_addr;

  assign ack        = (phase_q == PH_B) ? ctrl_b_out_enable_i : ctrl_x_out_enable_i;
  assign phase_size = (phase_q == PH_B) ? size_l_q : size_x_q;
  assign last_elem  = !((CW'(index_q) + CW'(1)) < CW'(phase_size));
  // Result slots are exactly L long; anything past that is discarded.
  assign h_fit      = CW'(count_q) < CW'(size_l_q);
  assign h_total    = (ctrl_h_out_enable_i && h_fit) ? CW'(count_q) + CW'(1) : CW'(count_q);
  // Address arithmetic is truncated to AW bits, so it wraps around the memory.
  assign rd_addr    = base_q + ((phase_q == PH_X) ? AW'(size_l_q) : '0) + AW'(index_q);
  assign wr_addr    = base_q + AW'(size_l_q) + AW'(size_x_q) + AW'(count_q);

  assign error_o     = error_q;
  assign mem_write_o = wr_vld_q;
  assign mem_data_o  = wr_data_q;

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Datapath registers: latched operands, counters, held element data and pending write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q   <= PH_B;
      index_q   <= '0;
      count_q   <= '0;
      size_l_q  <= '0;
      size_x_q  <= '0;
      base_q    <= '0;
      b_data_q  <= '0;
      x_data_q  <= '0;
      error_q   <= 1'b0;
      wr_vld_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      phase_q   <= phase_d;
      index_q   <= index_d;
      count_q   <= count_d;
      size_l_q  <= size_l_d;
      size_x_q  <= size_x_d;
      base_q    <= base_d;
      b_data_q  <= b_data_d;
      x_data_q  <= x_data_d;
      error_q   <= error_d;
      wr_vld_q  <= wr_vld_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    index_d   = index_q;
    count_d   = count_q;
    size_l_d  = size_l_q;
    size_x_d  = size_x_q;
    base_d    = base_q;
    b_data_d  = b_data_q;
    x_data_d  = x_data_q;
    error_d   = error_q;
    wr_vld_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    advance   = 1'b0;

    mem_read_o         = 1'b0;
    mem_address_o      = '0;
    ctrl_start_o       = 1'b0;
    ready_o            = 1'b0;
    ctrl_b_in_enable_o = 1'b0;
    ctrl_x_in_enable_o = 1'b0;
    ctrl_b_in_o        = b_data_q;
    ctrl_x_in_o        = x_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          size_l_d = size_l_i;
          size_x_d = size_x_i;
          base_d   = mem_base_i;
          error_d  = 1'b0;
          index_d  = '0;
          count_d  = '0;
          if (size_l_i != '0) begin
            phase_d = PH_B;
            state_d = S_FETCH;
          end else if (size_x_i != '0) begin
            phase_d = PH_X;
            state_d = S_FETCH;
          end else begin
            phase_d = PH_X;
            state_d = S_LAUNCH;
          end
        end
      end
      S_FETCH: begin
        mem_read_o    = 1'b1;
        mem_address_o = rd_addr;
        state_d       = S_PRESENT;
      end
      S_PRESENT: begin
        // Read data arrives this cycle: forward it now and keep a copy for WAIT_ACK.
        if (phase_q == PH_B) begin
          ctrl_b_in_enable_o = 1'b1;
          ctrl_b_in_o        = mem_data_i;
          b_data_d           = mem_data_i;
        end else begin
          ctrl_x_in_enable_o = 1'b1;
          ctrl_x_in_o        = mem_data_i;
          x_data_d           = mem_data_i;
        end
        if (ack) advance = 1'b1;
        else     state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ack) advance = 1'b1;
      end
      S_LAUNCH: begin
        ctrl_start_o = 1'b1;
        count_d      = '0;
        state_d      = S_COLLECT;
      end
      S_COLLECT: begin
        if (ctrl_h_out_enable_i) begin
          if (h_fit) begin
            wr_vld_d  = 1'b1;
            wr_addr_d = wr_addr;
            wr_data_d = ctrl_h_out_i;
            count_d   = count_q + CONTROL_SIZE'(1);
          end else begin
            error_d = 1'b1;
          end
        end
        // A same-cycle result is already folded into h_total.
        if (ctrl_ready_i) begin
          state_d = S_DONE;
          if (h_total != CW'(size_l_q)) error_d = 1'b1;
        end
      end
      S_DONE: begin
        ready_o = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (!last_elem) begin
        index_d = index_q + CONTROL_SIZE'(1);
        state_d = S_FETCH;
      end else if (phase_q == PH_B) begin
        phase_d = PH_X;
        index_d = '0;
        state_d = (size_x_q == '0) ? S_LAUNCH : S_FETCH;
      end else begin
        state_d = S_LAUNCH;
      end
    end

    // Pending writes never overlap a fetch, so the address port is shared.
    if (wr_vld_q) mem_address_o = wr_addr_q;
  end

endmodule

// File: tb/tb_accelerator_lstm_sequencer.sv
// Bench for accelerator_lstm_sequencer: word-memory model, acknowledging controller model and a scoreboard.
// Expected reads, element presentations and writes are queued when a step is started and popped as the DUT produces them.
// All waits on DUT events are bounded.
module tb_accelerator_lstm_sequencer;

  typedef struct {
    logic [63:0] d;
    logic [15:0] a;
    int          c;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        ready, error;
  logic [63:0] size_x, size_l;
  logic [15:0] mem_base, mem_address;
  logic        mem_read, mem_write;
  logic [63:0] rdata, mem_data_o;
  logic        ctrl_start, ctrl_ready;
  logic        b_en, x_en, b_ack, x_ack;
  logic [63:0] b_in, x_in;
  logic        h_en;
  logic [63:0] h_out;

  logic        ack_same;
  logic        b_dly, x_dly, b_seen, x_seen;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_cnt = 0;

  ev_t q_rd[$];
  ev_t q_b[$];
  ev_t q_x[$];
  ev_t q_wr[$];

  logic [63:0] mem [0:65535];

  always #5 clk = ~clk;

  accelerator_lstm_sequencer dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .start_i             (start),
    .ready_o             (ready),
    .error_o             (error),
    .size_x_i            (size_x),
    .size_l_i            (size_l),
    .mem_base_i          (mem_base),
    .mem_address_o       (mem_address),
    .mem_read_o          (mem_read),
    .mem_data_i          (rdata),
    .mem_write_o         (mem_write),
    .mem_data_o          (mem_data_o),
    .ctrl_start_o        (ctrl_start),
    .ctrl_ready_i        (ctrl_ready),
    .ctrl_b_in_enable_o  (b_en),
    .ctrl_x_in_enable_o  (x_en),
    .ctrl_b_in_o         (b_in),
    .ctrl_x_in_o         (x_in),
    .ctrl_b_out_enable_i (b_ack),
    .ctrl_x_out_enable_i (x_ack),
    .ctrl_h_out_enable_i (h_en),
    .ctrl_h_out_i        (h_out)
  );

  assign b_ack = ack_same ? b_en : b_dly;
  assign x_ack = ack_same ? x_en : x_dly;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_read) rdata <= mem[mem_address];
    if (mem_write) mem[mem_address] = mem_data_o;
  end

  // Controller model: acknowledge one cycle after each enable (when not in same-cycle mode).
  initial begin
    b_dly = 1'b0;
    x_dly = 1'b0;
    forever begin
      @(negedge clk);
      b_seen = b_en;
      x_seen = x_en;
      @(posedge clk);
      #1;
      b_dly = b_seen;
      x_dly = x_seen;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare every DUT-produced event against the head of its queue.
  always @(negedge clk) begin
    ev_t e;
    if (rst_n === 1'b1) begin
      if (mem_read) begin
        chk("rd_expected", 64'(q_rd.size() != 0), 64'd1);
        if (q_rd.size() != 0) begin
          e = q_rd.pop_front();
          chk("rd_addr", 64'(mem_address), 64'(e.a));
          chk("rd_cycle", 64'(cyc), 64'(e.c));
        end
      end
      if (b_en) begin
        chk("b_expected", 64'(q_b.size() != 0), 64'd1);
        if (q_b.size() != 0) begin
          e = q_b.pop_front();
          chk("b_data", b_in, e.d);
          chk("b_cycle", 64'(cyc), 64'(e.c));
        end
      end
      if (x_en) begin
        chk("x_expected", 64'(q_x.size() != 0), 64'd1);
        if (q_x.size() != 0) begin
          e = q_x.pop_front();
          chk("x_data", x_in, e.d);
          chk("x_cycle", 64'(cyc), 64'(e.c));
        end
      end
      if (mem_write) begin
        chk("wr_expected", 64'(q_wr.size() != 0), 64'd1);
        if (q_wr.size() != 0) begin
          e = q_wr.pop_front();
          chk("wr_addr", 64'(mem_address), 64'(e.a));
          chk("wr_data", mem_data_o, e.d);
          chk("wr_cycle", 64'(cyc), 64'(e.c));
        end
      end
      if (ready) ready_cnt++;
    end
  end

  function automatic logic all_out_or();
    return |{ready, error, mem_address, mem_read, mem_write, mem_data_o,
             ctrl_start, b_en, x_en, b_in, x_in};
  endfunction

  // One complete LSTM step. mode 0: acks in the enable cycle, mode 1: acks one cycle later.
  task automatic run_step(input logic [15:0] base, input int l, input int x, input int mode,
                          input logic [63:0] dval, input int nres, input logic [63:0] rval,
                          input bit glitch, input bit same_last);
    int  c0, per, tl, th, rc0, n;
    bit  got;
    ev_t e;
    per = (mode != 0) ? 3 : 2;
    n   = l + x;
    for (int k = 0; k < n; k++) mem[base + 16'(k)] = dval + 64'(k);
    ack_same = (mode == 0);
    size_l   = 64'(l);
    size_x   = 64'(x);
    mem_base = base;
    rc0      = ready_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    c0    = cyc;
    for (int k = 0; k < n; k++) begin
      e.a = base + 16'(k);
      e.d = 64'd0;
      e.c = c0 + 1 + k * per;
      q_rd.push_back(e);
      e.a = 16'd0;
      e.d = dval + 64'(k);
      e.c = c0 + 2 + k * per;
      if (k < l) q_b.push_back(e);
      else       q_x.push_back(e);
    end
    @(posedge clk); #1;
    start    = 1'b0;
    // Operands must have been latched: scramble the live inputs.
    size_l   = 64'hFF;
    size_x   = 64'hFF;
    mem_base = 16'h5A5A;
    chk("error_cleared_by_start", 64'(error), 64'd0);
    if (glitch) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    tl  = -1;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (ctrl_start) begin
        tl  = cyc;
        got = 1'b1;
      end
    end
    chk("launch_seen", 64'(got), 64'd1);
    if (!got) return;
    chk("launch_cycle", 64'(tl), 64'(c0 + 1 + per * n));
    th = tl;
    for (int j = 0; j < nres; j++) begin
      @(posedge clk); #1;
      h_en  = 1'b1;
      h_out = rval + 64'(j);
      if (j < l) begin
        e.a = base + 16'(l + x + j);
        e.d = rval + 64'(j);
        e.c = cyc + 1;
        q_wr.push_back(e);
      end
      if (same_last && j == nres - 1) begin
        ctrl_ready = 1'b1;
        th = cyc;
      end
    end
    if (!(same_last && nres > 0)) begin
      @(posedge clk); #1;
      h_en       = 1'b0;
      ctrl_ready = 1'b1;
      th = cyc;
    end
    @(posedge clk); #1;
    h_en       = 1'b0;
    h_out      = 64'd0;
    ctrl_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ready) got = 1'b1;
    end
    chk("ready_seen", 64'(got), 64'd1);
    chk("ready_cycle", 64'(cyc), 64'(th + 1));
    chk("error_at_ready", 64'(error), 64'(nres != l));
    @(posedge clk); #1;
    chk("error_sticky", 64'(error), 64'(nres != l));
    chk("ready_pulses", 64'(ready_cnt - rc0), 64'd1);
    chk("scoreboard_drained", 64'(q_rd.size() + q_b.size() + q_x.size() + q_wr.size()), 64'd0);
    q_rd.delete(); q_b.delete(); q_x.delete(); q_wr.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0, rc0;
    ev_t e;
    for (int i = 0; i < 65536; i++) mem[i] = 64'd0;
    rst_n = 1'b0; start = 1'b0; size_x = '0; size_l = '0; mem_base = '0;
    ctrl_ready = 1'b0; h_en = 1'b0; h_out = '0; ack_same = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", 64'(all_out_or()), 64'd0);
    rst_n = 1'b1;

    // Nominal step: acks one cycle late, 3 cycles per element.
    run_step(16'h0010, 2, 3, 1, 64'd1, 2, 64'hA, 1'b0, 1'b0);
    chk("mem_0x15", mem[16'h0015], 64'hA);
    chk("mem_0x16", mem[16'h0016], 64'hB);
    // Same-cycle acks: enables at cycles 2 and 4, launch at 5.
    run_step(16'h0020, 1, 1, 0, 64'h100, 1, 64'h200, 1'b0, 1'b0);
    // No bias vector.
    run_step(16'h0030, 0, 2, 0, 64'h300, 0, 64'h400, 1'b0, 1'b0);
    // Short result stream sets ERROR; next START clears it.
    run_step(16'h0050, 2, 1, 0, 64'h500, 1, 64'h600, 1'b0, 1'b0);
    // START during WAIT_ACK is ignored.
    run_step(16'h0060, 1, 2, 1, 64'h700, 1, 64'h800, 1'b1, 1'b0);
    // Extra result is dropped and flagged.
    run_step(16'h0070, 1, 0, 0, 64'h900, 2, 64'hA00, 1'b0, 1'b0);

    // Reset while a write is pending in COLLECT.
    size_l = 64'd1; size_x = 64'd0; mem_base = 16'h0040; mem[16'h0040] = 64'hC0DE; ack_same = 1'b1;
    rc0 = ready_cnt;
    @(posedge clk); #1;
    start = 1'b1;
    c0 = cyc;
    e.a = 16'h0040; e.d = 64'd0;     e.c = c0 + 1; q_rd.push_back(e);
    e.a = 16'h0000; e.d = 64'hC0DE;  e.c = c0 + 2; q_b.push_back(e);
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    h_en = 1'b1; h_out = 64'h77;
    @(posedge clk); #1;
    h_en = 1'b0; h_out = 64'd0;
    chk("pre_reset_write", 64'(mem_write), 64'd1);
    chk("pre_reset_addr", 64'(mem_address), 64'h41);
    chk("pre_reset_data", mem_data_o, 64'h77);
    #1 rst_n = 1'b0;
    #1 chk("reset_mid_outputs_zero", 64'(all_out_or()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("reset_no_ready", 64'(ready_cnt - rc0), 64'd0);
    chk("reset_scoreboard", 64'(q_rd.size() + q_b.size()), 64'd0);
    run_step(16'h0080, 1, 1, 1, 64'hB00, 1, 64'hC00, 1'b0, 1'b0);

    // Address wrap, last result in the same cycle as CTRL_READY.
    run_step(16'hFFFE, 2, 1, 0, 64'hD00, 2, 64'hE00, 1'b0, 1'b1);
    chk("mem_wrap_0001", mem[16'h0001], 64'hE00);
    chk("mem_wrap_0002", mem[16'h0002], 64'hE01);
    // Empty vectors: launch one cycle after START.
    run_step(16'h0090, 0, 0, 0, 64'hF00, 0, 64'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
